store_buffer: RTL and testbench

//  Posted-write buffer between the MEM stage (EX_MEM outputs) and a multi-cycle data memory port.

---
 rtl/store_buffer.sv | 182 ++++++++++++++++++
 tb/tb_store_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the MEM stage and a multi-cycle data memory.
//
// Stores retire into a small circular FIFO in one cycle and drain to memory over a
// req/ack handshake. Loads that hit a buffered word are forwarded from the youngest
// matching entry with no stall. Loads that miss stall the pipeline until memory returns data.
//
// Ports:
//   clk, rst             system clock; synchronous active-high reset
//   mem_read, mem_write  load / store in the MEM stage (both set counts as a store)
//   addr, wdata          byte address and store data from EX_MEM
//   rdata                load data to MEM_WB (valid when mem_read=1 and stall=0)
//   stall                hold PC, IF_ID, ID_EX, EX_MEM, MEM_WB this cycle
//   dm_req/we/addr/wdata memory request, held stable until dm_ack
//   dm_ack, dm_rdata     memory completion and read data
//   sb_count             number of occupied entries
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [AW-1:0]          addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   stall,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [AW-1:0]          dm_addr,
    output logic [31:0]            dm_wdata,
    input  logic                   dm_ack,
    input  logic [31:0]            dm_rdata,
    output logic [$clog2(DEPTH):0] sb_count
);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StLdone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ent_addr_q [DEPTH];
    logic [AW-1:0]     ent_addr_d [DEPTH];
    logic [31:0]       ent_data_q [DEPTH];
    logic [31:0]       ent_data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [AW-1:0]     dm_addr_q, dm_addr_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;
    logic [31:0]       ld_data_q, ld_data_d;

    logic              ld, full, empty, enq, pop, hit;
    logic [31:0]       hit_data;
    logic [PW-1:0]     idx;

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (ent_addr_q[idx][AW-1:2] == addr[AW-1:2])) begin
                hit      = 1'b1;
                hit_data = ent_data_q[idx];
            end
        end
    end

    always_comb begin
        ld    = mem_read & ~mem_write;
        full  = (count_q == (PW+1)'(DEPTH));
        empty = (count_q == '0);
        // A slot freed by this cycle's ack is not usable until the next cycle.
        enq   = mem_write & ~full;
        pop   = (state_q == StWrite) & dm_ack;
        stall = (mem_write & full) | (ld & ~hit & (state_q != StLdone));
        rdata = (state_q == StLdone) ? ld_data_q : hit_data;
    end

    // FIFO storage update
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (enq) begin
            valid_d[tail_q]    = 1'b1;
            ent_addr_d[tail_q] = addr;
            ent_data_d[tail_q] = wdata;
            tail_d             = tail_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(enq) - (PW+1)'(pop);
    end

    // Memory-port FSM; loads take priority over draining when idle.
    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        ld_data_d  = ld_data_q;
        unique case (state_q)
            StIdle: begin
                if (ld && !hit) begin
                    state_d   = StRead;
                    dm_req_d  = 1'b1;
                    dm_we_d   = 1'b0;
                    dm_addr_d = addr;
                end else if (!empty) begin
                    state_d    = StWrite;
                    dm_req_d   = 1'b1;
                    dm_we_d    = 1'b1;
                    dm_addr_d  = ent_addr_q[head_q];
                    dm_wdata_d = ent_data_q[head_q];
                end
            end
            StWrite: begin
                if (dm_ack) begin
                    dm_req_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            StRead: begin
                if (dm_ack) begin
                    dm_req_d  = 1'b0;
                    ld_data_d = dm_rdata;
                    state_d   = StLdone;
                end
            end
            StLdone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            ld_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            ld_data_q  <= ld_data_d;
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign sb_count = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic for store_buffer.
// The reference is a program-order store queue and a word-addressed memory array;
// the bench also plays the memory side with a configurable ack latency.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int NOACK = 1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        stall;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  sb_count;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .sb_count (sb_count)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [256];
    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic [31:0] req_log [$];
    int          lat = 1;
    int          age = 0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Youngest buffered store to the same word wins; otherwise memory content.
    function automatic logic model_lookup(input logic [31:0] a, output logic [31:0] d);
        logic h;
        h = 1'b0;
        d = mem[a[9:2]];
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i][31:2] == a[31:2]) begin
                h = 1'b1;
                d = q_data[i];
            end
        end
        return h;
    endfunction

    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic first, output logic st);
        logic        h;
        logic [31:0] exp;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        dm_ack    = dm_req && (age >= lat);
        dm_rdata  = (dm_req && !dm_we) ? mem[dm_addr[9:2]] : $urandom;
        #1;
        st = stall;
        if (p_req && !p_ack) begin
            check("req_hold", dm_req, 1);
            check("we_hold", dm_we, p_we);
            check("addr_hold", dm_addr, p_addr);
            check("wdata_hold", dm_wdata, p_wdata);
        end
        if (p_req && p_ack) check("req_gap", dm_req, 0);
        if (dm_req && !p_req) req_log.push_back(dm_addr);
        check("sb_count", 32'(sb_count), q_addr.size());
        if (wr) check("st_stall", stall, 32'(q_addr.size() == DEPTH));
        if (rd && !wr) begin
            h = model_lookup(a, exp);
            if (h) check("ld_hit_stall", stall, 0);
            else if (first) check("ld_miss_stall", stall, 1);
            if (!stall) check("ld_data", rdata, exp);
        end
        if (dm_req && dm_ack && dm_we) begin
            check("wr_nonempty", 32'(q_addr.size() != 0), 1);
            if (q_addr.size() != 0) begin
                check("wr_addr", dm_addr, q_addr[0]);
                check("wr_data", dm_wdata, q_data[0]);
                mem[dm_addr[9:2]] = dm_wdata;
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
        end
        if (wr && !stall) begin
            q_addr.push_back(a);
            q_data.push_back(d);
        end
        p_req   = dm_req;
        p_ack   = dm_ack;
        p_we    = dm_we;
        p_addr  = dm_addr;
        p_wdata = dm_wdata;
        if (dm_req && !dm_ack) age++;
        else age = 0;
    endtask

    // Hold one instruction in MEM until the buffer stops stalling it.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int n);
        logic st;
        n = 0;
        do begin
            step(rd, wr, a, d, n == 0, st);
            n++;
        end while (st && n < 200);
        if (st) check("op_timeout", st, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dm_ack    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req", dm_req, 0);
        check("rst_we", dm_we, 0);
        check("rst_addr", dm_addr, 0);
        check("rst_wdata", dm_wdata, 0);
        check("rst_count", 32'(sb_count), 0);
        check("rst_stall", stall, 0);
        rst = 1'b0;
        q_addr.delete();
        q_data.delete();
        age   = 0;
        p_req = 1'b0;
        p_ack = 1'b0;
    endtask

    initial begin
        int          n;
        int          r;
        logic        st;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        do_reset();

        // Single store drained with one-cycle ack latency
        lat = 1;
        do_op(0, 1, 32'h10, 32'hAA, n);
        check("t1_stall_cycles", n, 1);
        repeat (5) do_op(0, 0, 0, 0, n);
        check("t1_mem", mem[4], 32'hAA);
        check("t1_empty", 32'(sb_count), 0);

        // Forwarding from the youngest of two stores to one word
        lat = NOACK;
        do_op(0, 1, 32'h20, 32'h1, n);
        do_op(0, 1, 32'h20, 32'h2, n);
        do_op(1, 0, 32'h22, 0, n);
        check("t2_rdata", rdata, 32'h2);
        check("t2_stall_cycles", n, 1);

        // Full buffer: store stalls, including on the ack cycle, then enqueues
        do_op(0, 1, 32'h24, 32'h3, n);
        do_op(0, 1, 32'h28, 32'h4, n);
        step(0, 1, 32'h2C, 32'h5, 1, st);
        check("t3_full_stall", st, 1);
        check("t3_count", 32'(sb_count), DEPTH);
        lat = 0;
        step(0, 1, 32'h2C, 32'h5, 0, st);
        check("t3_ack_stall", st, 1);
        lat = NOACK;
        step(0, 1, 32'h2C, 32'h5, 0, st);
        check("t3_enq", st, 0);
        step(0, 0, 0, 0, 1, st);
        check("t3_count_after", 32'(sb_count), DEPTH);
        lat = 1;
        repeat (20) do_op(0, 0, 0, 0, n);
        check("t3_drained", 32'(sb_count), 0);
        check("t3_mem", mem[8'h0B], 32'h5);

        // Load miss with memory latency 3
        mem[8'h0C] = 32'h1234;
        lat = 3;
        do_op(1, 0, 32'h30, 0, n);
        check("t4_stall_cycles", n - 1, 5);
        check("t4_rdata", rdata, 32'h1234);

        // Load miss during a pending write: write first, then read
        lat = 2;
        req_log.delete();
        do_op(0, 1, 32'h40, 32'h7, n);
        do_op(0, 0, 0, 0, n);
        do_op(0, 0, 0, 0, n);
        do_op(1, 0, 32'h44, 0, n);
        check("t5_req_count", req_log.size(), 2);
        if (req_log.size() == 2) begin
            check("t5_first", req_log[0], 32'h40);
            check("t5_second", req_log[1], 32'h44);
        end

        // Reset during a write with three buffered stores
        lat = NOACK;
        do_op(0, 1, 32'h50, 32'h11, n);
        do_op(0, 1, 32'h54, 32'h22, n);
        do_op(0, 1, 32'h58, 32'h33, n);
        step(0, 0, 0, 0, 1, st);
        check("t6_pre_count", 32'(sb_count), 3);
        check("t6_pre_req", dm_req, 1);
        do_reset();
        lat = 1;
        do_op(1, 0, 32'h50, 0, n);
        check("t6_miss_cycles", n, 4);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            r   = $urandom_range(0, 9);
            lat = $urandom_range(0, 4);
            a   = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            if (r < 4) do_op(0, 1, a, $urandom, n);
            else if (r < 7) do_op(1, 0, a, 0, n);
            else do_op(0, 0, 0, 0, n);
        end
        lat = 1;
        repeat (30) do_op(0, 0, 0, 0, n);
        check("final_empty", 32'(sb_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
